// File: rtl/slugtpu_arb_pkg.sv
// slugtpu_arb_pkg: shared types and index helpers for the round-robin FIFO arbiter
package slugtpu_arb_pkg;
  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} arb_state_e;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  // a is at most 2n-2 here, so one subtraction brings it back into range
  function automatic int wrap(input int a, input int n);
    return (a >= n) ? a - n : a;
  endfunction
endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder scanning from ptr upward with wrap
//   req    in  N      request vector
//   ptr    in  ID_W   highest-priority index
//   gnt    out N      one-hot grant, zero when no request
//   gnt_id out ID_W   granted index, zero when no request
//   any    out 1      some request is present
module rr_pick
  import slugtpu_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    for (int i = 0; i < N; i++)
      if (!any && req[wrap(int'(ptr) + i, N)]) begin
        any    = 1'b1;
        gnt_id = ID_W'(wrap(int'(ptr) + i, N));
      end
    gnt[gnt_id] = any;
  end
endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin sharing of one FIFO write port among NUM_REQ_P valid/ready streams
//   clk_i, rst_ni (sync, active-low)
//   req_valid_i/req_data_i/req_last_i/req_ready_o  per-requester streams (data packed k*WIDTH_P)
//   data_o/valid_o/ready_i                         FIFO write port
//   grant_o/grant_id_o                             current grant, zero when none
//   SLUGTPU_ARB_BURST_LOCK_EN enables burst lock (up to BURST_P beats or until last)
module fifo_rr_arbiter
  import slugtpu_arb_pkg::*;
#(
  parameter int NUM_REQ_P = 4,
  parameter int WIDTH_P   = 8,
  parameter int BURST_P   = 4,
  localparam int ID_W     = id_width(NUM_REQ_P)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_REQ_P-1:0]         req_valid_i,
  input  logic [NUM_REQ_P*WIDTH_P-1:0] req_data_i,
  input  logic [NUM_REQ_P-1:0]         req_last_i,
  output logic [NUM_REQ_P-1:0]         req_ready_o,
  output logic [WIDTH_P-1:0]           data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [NUM_REQ_P-1:0]         grant_o,
  output logic [ID_W-1:0]              grant_id_o
);
  logic [ID_W-1:0]      r_ptr, w_ptr_nxt, w_ptr_inc, w_pick_id, w_lock_id, w_id;
  logic [NUM_REQ_P-1:0] w_pick_gnt, w_gnt;
  logic                 w_any, w_lock, w_has, w_xfer;
  rr_pick #(.N(NUM_REQ_P), .ID_W(ID_W)) u_pick (
    .req    (req_valid_i),
    .ptr    (r_ptr),
    .gnt    (w_pick_gnt),
    .gnt_id (w_pick_id),
    .any    (w_any)
  );
  assign w_id      = w_lock ? w_lock_id : w_pick_id;
  assign w_gnt     = w_lock ? NUM_REQ_P'(1) << w_lock_id : w_pick_gnt;
  assign w_has     = w_lock | w_any;
  assign w_ptr_inc = ID_W'(wrap(int'(w_id) + 1, NUM_REQ_P));
  // valid_o depends only on requester valids and registered state, never on ready_i
  always_comb begin
    grant_o     = (rst_ni && w_has) ? w_gnt : '0;
    grant_id_o  = (rst_ni && w_has) ? w_id : '0;
    valid_o     = rst_ni && w_has && req_valid_i[w_id];
    data_o      = (rst_ni && w_has) ? req_data_i[w_id*WIDTH_P +: WIDTH_P] : '0;
    req_ready_o = (rst_ni && w_has) ? w_gnt & {NUM_REQ_P{ready_i}} : '0;
    w_xfer      = valid_o && ready_i;
  end
`ifdef SLUGTPU_ARB_BURST_LOCK_EN
  localparam int CNT_W = $clog2(BURST_P + 1);
  arb_state_e       r_state, w_state_nxt;
  logic [ID_W-1:0]  r_owner, w_owner_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_last;
  assign w_lock    = r_state == LOCK;
  assign w_lock_id = r_owner;
  assign w_last    = req_last_i[w_id];
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  // ptr only moves when a grant ends, so a locked burst does not shift priority
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    if (w_xfer) begin
      if (w_lock) begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_last || int'(r_cnt) + 1 == BURST_P) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = w_ptr_inc;
        end
      end else if (!w_last && BURST_P > 1) begin
        w_state_nxt = LOCK;
        w_owner_nxt = w_id;
        w_cnt_nxt   = CNT_W'(1);
      end else
        w_ptr_nxt = w_ptr_inc;
    end
  end
`else
  logic w_unused;
  assign w_unused  = ^req_last_i;
  assign w_lock    = 1'b0;
  assign w_lock_id = '0;
  assign w_ptr_nxt = w_xfer ? w_ptr_inc : r_ptr;
  always_ff @(posedge clk_i)
    if (!rst_ni) r_ptr <= '0;
    else r_ptr <= w_ptr_nxt;
`endif
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: directed self-checking bench for fifo_rr_arbiter
module tb_fifo_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n, ready, valid_o, valid3_o;
  logic [3:0]  valid, last, ready_o, grant;
  logic [31:0] data = 32'hA3A2A1A0;
  logic [7:0]  data_o, data3_o;
  logic [1:0]  id, id3;
  logic [2:0]  valid3, grant3, ready3_o;
  logic [2:0]  last3 = 3'b111;
  logic [23:0] data3 = 24'hC2C1C0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fifo_rr_arbiter #(.NUM_REQ_P(4), .WIDTH_P(8), .BURST_P(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_data_i(data), .req_last_i(last),
    .req_ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready),
    .grant_o(grant), .grant_id_o(id)
  );
  fifo_rr_arbiter #(.NUM_REQ_P(3), .WIDTH_P(8), .BURST_P(4)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid3), .req_data_i(data3), .req_last_i(last3),
    .req_ready_o(ready3_o), .data_o(data3_o), .valid_o(valid3_o), .ready_i(ready),
    .grant_o(grant3), .grant_id_o(id3)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic exp_gnt(input string tag, input int k);
    chk({tag, "_id"}, 32'(id), 32'(k));
    chk({tag, "_data"}, 32'(data_o), 32'h0A0 + 32'(k));
    chk({tag, "_grant"}, 32'(grant), 32'(1) << k);
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    #1;
  endtask
  initial begin
    rst_n = 1'b0; valid = 4'hF; last = 4'hF; ready = 1'b1; valid3 = 3'b000;
    tick;
    tick;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_id", 32'(id), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    rst_n = 1'b1;
    #1;
    exp_gnt("first", 0);
    chk("first_ready", 32'(ready_o), 32'd1);
    chk("first_valid", 32'(valid_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      exp_gnt("rot", i % 4);
      tick;
    end
    do_reset;
    valid = 4'b1000;
    #1;
    exp_gnt("wrap3", 3);
    tick;
    valid = 4'b1001;
    #1;
    exp_gnt("wrap0", 0);
    tick;
    exp_gnt("skip3", 3);
    tick;
    valid = 4'b0000;
    #1;
    chk("none_valid", 32'(valid_o), 32'd0);
    chk("none_grant", 32'(grant), 32'd0);
    do_reset;
    valid3 = 3'b111;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("n3_id", 32'(id3), 32'(i % 3));
      chk("n3_data", 32'(data3_o), 32'h0C0 + 32'(i % 3));
      tick;
    end
    valid3 = 3'b000;
`ifdef SLUGTPU_ARB_BURST_LOCK_EN
    begin
      int seq_b[7] = '{2, 2, 2, 2, 3, 0, 2};
      int seq_p[4] = '{0, 0, 0, 1};
      do_reset;
      valid = 4'b0010; last = 4'hF;
      #1;
      exp_gnt("cap_pre", 1);
      tick;
      valid = 4'b1101; last = 4'b1001;
      #1;
      for (int i = 0; i < 7; i++) begin
        exp_gnt("cap", seq_b[i]);
        tick;
      end
      do_reset;
      valid = 4'b0001; last = 4'b0000;
      #1;
      exp_gnt("bp_first", 0);
      tick;
      valid = 4'hF; ready = 1'b0;
      #1;
      repeat (5) begin
        exp_gnt("bp_hold", 0);
        chk("bp_ready", 32'(ready_o), 32'd0);
        chk("bp_valid", 32'(valid_o), 32'd1);
        tick;
      end
      ready = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
        exp_gnt("bp_resume", seq_p[i]);
        tick;
      end
      do_reset;
      valid = 4'b0001; last = 4'b0000;
      #1;
      exp_gnt("bub_first", 0);
      tick;
      valid = 4'b1110;
      #1;
      repeat (2) begin
        chk("bub_valid", 32'(valid_o), 32'd0);
        chk("bub_id", 32'(id), 32'd0);
        chk("bub_grant", 32'(grant), 32'd1);
        tick;
      end
      valid = 4'hF; last = 4'hF;
      #1;
      exp_gnt("bub_last", 0);
      tick;
      exp_gnt("bub_next", 1);
    end
`else
    do_reset;
    valid = 4'hF; last = 4'b0000; ready = 1'b0;
    #1;
    repeat (5) begin
      exp_gnt("bp_hold", 0);
      chk("bp_ready", 32'(ready_o), 32'd0);
      chk("bp_valid", 32'(valid_o), 32'd1);
      tick;
    end
    ready = 1'b1;
    #1;
    exp_gnt("bp_resume", 0);
    chk("bp_ready1", 32'(ready_o), 32'd1);
    tick;
    exp_gnt("bp_next", 1);
    do_reset;
    valid = 4'b0001;
    #1;
    exp_gnt("alt_pre", 0);
    tick;
    valid = 4'b0011;
    #1;
    for (int i = 0; i < 5; i++) begin
      exp_gnt("alt", (i % 2 == 0) ? 1 : 0);
      tick;
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
